sb_at_cmd_initiator: RTL
========================

Name: sb_at_cmd_initiator

Overview:
- Sideband AT-command initiator running in the sb_clk domain.
- Accepts a register-access request, serializes it as a 5-byte frame onto the sideband TX byte stream, then arms the command-response timer (cmd_cnt_start) and waits for a matching response.
- Consumes tCmdResponse_timeout from the timer block, retries up to MAX_RETRY times, and reports done or fail.
- It is the requester/consumer end of the timer's cmd_cnt_start / cmd_cnt_end / tCmdResponse_timeout interface.

Parameters:
- SOF_BYTE, 8'hFE, first byte of every command frame.
- EOF_BYTE, 8'h40, last byte of every command frame.
- MAX_RETRY, 2, number of re-sends after the first attempt times out (range 0..3).

Ports:
- sb_clk  input  1  sideband clock (1 MHz); only clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  command request.
- req_ready  output  1  high only in IDLE; request accepted on req_valid & req_ready.
- req_addr  input  8  target register address.
- req_rw  input  1  1 = write, 0 = read.
- req_len  input  7  byte count of the access.
- tx_valid  output  1  frame byte valid.
- tx_ready  input  1  TX path accepts byte.
- tx_data  output  8  frame byte.
- rsp_valid  input  1  response received (1-cycle pulse from RX parser).
- rsp_addr  input  8  address carried in response.
- tcmd_timeout  input  1  tCmdResponse_timeout from timer.
- cmd_cnt_start  output  1  1-cycle pulse arming the response timer.
- cmd_cnt_end  output  1  1-cycle pulse stopping the response timer.
- busy  output  1  high in any state other than IDLE.
- done  output  1  1-cycle pulse on successful response.
- fail  output  1  1-cycle pulse when retries are exhausted.
- retry_cnt  output  2  re-sends performed for the current command.

Behaviour:
- Reset (rst=1 at a sb_clk edge):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - retry_cnt=0; latched address and control are cleared.
  - Reset mid-frame or mid-wait abandons the command immediately, with no done, fail or cmd_cnt_end.
- States: IDLE, SEND, ARM, WAIT, FINISH.
- IDLE:
  - On req_valid, latch addr, ctrl = {rw, len} and chk = addr ^ ctrl.
  - Clear retry_cnt, byte index = 0, go to SEND.
  - tx_valid rises on the cycle after acceptance.
- SEND:
  - tx_data = byte[idx]: 0 SOF_BYTE, 1 addr, 2 ctrl, 3 chk, 4 EOF_BYTE.
  - tx_valid is held high; tx_data is stable while tx_ready=0.
  - On tx_valid & tx_ready, idx increments. The handshake on idx=4 goes to ARM, with tx_valid low the next cycle.
  - Back-pressure of any length is legal; frame bytes are never skipped or reordered.
- ARM: cmd_cnt_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - rsp_valid with rsp_addr == latched addr is a match: go to FINISH.
  - rsp_valid with a mismatched addr is ignored.
  - tcmd_timeout with retry_cnt < MAX_RETRY: retry_cnt++, idx = 0, go to SEND (full frame re-sent, then re-armed).
  - tcmd_timeout with retry_cnt == MAX_RETRY: fail=1 for one cycle, go to IDLE.
  - A match in the same cycle as tcmd_timeout: the match wins.
- FINISH: cmd_cnt_end=1 and done=1 for one cycle, then IDLE.
- Out-of-state inputs:
  - rsp_valid and tcmd_timeout outside WAIT are ignored.
  - req_valid while busy is not accepted (req_ready=0).
- retry_cnt holds its final value in IDLE until the next request is accepted.
- Minimum command latency, with tx_ready always 1 and the response arriving on the first WAIT cycle:
  - accept at T;
  - SOF..EOF on T+1..T+5;
  - cmd_cnt_start at T+6;
  - rsp at T+7;
  - done at T+8.

Test Plan:
- Clean read: addr=8'h2C, rw=0, len=7'd4, tx_ready=1 -> tx_data sequence FE,2C,04,28,40 on consecutive cycles; cmd_cnt_start one cycle after EOF; rsp_addr=2C -> done and cmd_cnt_end pulse next cycle, retry_cnt=0.
- Back-pressure: tx_ready low for 3 cycles on byte 2 -> ctrl byte held stable, no duplicate or skipped bytes, cmd_cnt_start still only after the EOF handshake.
- Timeout retry: no response, tcmd_timeout pulsed in WAIT -> frame re-sent in full, second cmd_cnt_start, retry_cnt=1; then matching rsp -> done, retry_cnt=1.
- Exhaustion: MAX_RETRY=2, three timeouts -> three frames and three cmd_cnt_start pulses, single fail pulse, retry_cnt=2, no done, returns to IDLE with req_ready=1.
- Mismatch and simultaneity: rsp_addr=8'h11 while waiting for 8'h2C -> ignored. Then matching rsp and tcmd_timeout in the same cycle -> done, no retry.
- Reset mid-wait: rst=1 in WAIT -> next cycle IDLE, busy=0, no done/fail/cmd_cnt_end; new request is accepted normally afterwards.

Source files
------------

// File: rtl/sb_at_cmd_initiator.sv
// -----------------------------------------------------------------------------
// sb_at_cmd_initiator
//
// Sideband AT-command initiator (sb_clk domain). It accepts one register-access
// request at a time and sends it as a 5-byte frame:
//   SOF_BYTE, addr, ctrl = {rw, len}, chk = addr ^ ctrl, EOF_BYTE
// It then arms the command-response timer and waits for a response that
// carries the same address. A response timeout re-sends the whole frame up to
// MAX_RETRY times before the command is reported as failed.
//
// Ports
//   sb_clk, rst        clock and synchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_addr/rw/len    register address, 1 = write, byte count
//   tx_valid/ready     outgoing frame byte handshake, tx_data = frame byte
//   rsp_valid/addr     response pulse from the RX parser and its address
//   tcmd_timeout       tCmdResponse_timeout from the timer block
//   cmd_cnt_start/end  1-cycle pulses that start / stop the response timer
//   busy               high whenever a command is in progress
//   done / fail        1-cycle completion pulses
//   retry_cnt          re-sends performed for the current or last command
// -----------------------------------------------------------------------------
module sb_at_cmd_initiator #(
  parameter logic [7:0] SOF_BYTE  = 8'hFE,
  parameter logic [7:0] EOF_BYTE  = 8'h40,
  parameter int         MAX_RETRY = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic       req_rw,
  input  logic [6:0] req_len,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_addr,
  input  logic       tcmd_timeout,
  output logic       cmd_cnt_start,
  output logic       cmd_cnt_end,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [1:0] LP_MAX_RETRY = 2'(MAX_RETRY);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_addr;
  logic [7:0] r_ctrl;
  logic [7:0] r_chk;
  logic [2:0] r_idx;
  logic [1:0] r_retry;
  logic       r_fail;

  logic       w_match;
  logic       w_can_retry;
  logic [7:0] w_req_ctrl;

  assign w_req_ctrl  = {req_rw, req_len};
  assign w_match     = rsp_valid && (rsp_addr == r_addr);
  assign w_can_retry = (r_retry < LP_MAX_RETRY);

  // Next-state logic. A matching response outranks a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_SEND;
      S_SEND:   if (tx_ready && (r_idx == 3'd4)) w_state_nxt = S_ARM;
      S_ARM:    w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_match)           w_state_nxt = S_FINISH;
        else if (tcmd_timeout) w_state_nxt = w_can_retry ? S_SEND : S_IDLE;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, frame fields and retry bookkeeping.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 8'd0;
      r_ctrl  <= 8'd0;
      r_chk   <= 8'd0;
      r_idx   <= 3'd0;
      r_retry <= 2'd0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fail  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_ctrl  <= w_req_ctrl;
            r_chk   <= req_addr ^ w_req_ctrl;
            r_idx   <= 3'd0;
            r_retry <= 2'd0;
          end
        end
        S_SEND: begin
          if (tx_ready) r_idx <= r_idx + 3'd1;
        end
        S_WAIT: begin
          if (!w_match && tcmd_timeout) begin
            if (w_can_retry) begin
              r_retry <= r_retry + 2'd1;
              r_idx   <= 3'd0;
            end else begin
              // fail is registered so it appears on the first idle cycle,
              // one cycle after the deciding timeout (same spacing as done).
              r_fail  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame byte selection; the bus is driven to zero outside of SEND.
  always_comb begin
    tx_data = 8'd0;
    if (r_state == S_SEND) begin
      case (r_idx)
        3'd0:    tx_data = SOF_BYTE;
        3'd1:    tx_data = r_addr;
        3'd2:    tx_data = r_ctrl;
        3'd3:    tx_data = r_chk;
        default: tx_data = EOF_BYTE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign tx_valid      = (r_state == S_SEND);
  assign cmd_cnt_start = (r_state == S_ARM);
  assign cmd_cnt_end   = (r_state == S_FINISH);
  assign done          = (r_state == S_FINISH);
  assign fail          = r_fail;
  assign retry_cnt     = r_retry;

endmodule
